// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Controller for a single-port-strobe FIFO memory. The memory itself lives
// outside this block. It accepts a write strobe or a read strobe per cycle,
// never both, and returns read data one cycle after the read strobe. This block
// owns the read and write pointers, the occupancy count and the status flags.
// It arbitrates between a push requester and a pop requester.
//
// Ports
//   clk           in   single clock, all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   push_req      in   upstream requests a write
//   push_data     in   word to be written (DATA_SIZE)
//   push_ack      out  write granted this cycle
//   pop_req       in   downstream requests a read
//   pop_ack       out  read granted this cycle
//   pop_valid     out  memory rd_data holds the popped word this cycle
//   wr_fifo       out  memory write strobe
//   wr_addr       out  memory write address (ADDR_DEPTH bits, zero-extended)
//   wr_data       out  memory write data (wired from push_data)
//   rd_fifo       out  memory read strobe
//   rd_addr       out  memory read address (ADDR_DEPTH bits, zero-extended)
//   count         out  current occupancy, 0..ADDR_DEPTH
//   full, empty, almost_full, almost_empty
//                 out  status flags decoded from the registered count
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_DEPTH = 16,
    parameter int AF_LEVEL   = ADDR_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int PTR_W     = $clog2(ADDR_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_req,
    input  logic [DATA_SIZE-1:0]  push_data,
    output logic                  push_ack,
    input  logic                  pop_req,
    output logic                  pop_ack,
    output logic                  pop_valid,
    output logic                  wr_fifo,
    output logic [ADDR_DEPTH-1:0] wr_addr,
    output logic [DATA_SIZE-1:0]  wr_data,
    output logic                  rd_fifo,
    output logic [ADDR_DEPTH-1:0] rd_addr,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    // Which side wins when both requests are eligible in the same cycle.
    typedef enum logic {
        PRIO_WRITE = 1'b0,
        PRIO_READ  = 1'b1
    } prio_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    prio_e            prio_q,   prio_d;
    logic             pop_valid_q;

    // -------------------------------------------------------------------------
    // Status flags, decoded from the registered count only
    // -------------------------------------------------------------------------
    logic full_w;
    logic empty_w;

    assign full_w       = (count_q == CNT_W'(ADDR_DEPTH));
    assign empty_w      = (count_q == '0);
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // Eligibility looks only at registered flags, so a pop against an empty
    // FIFO is refused even when a push lands in the same cycle (no
    // fall-through). A push against a full FIFO is refused in the same way.
    logic wr_elig;
    logic rd_elig;
    logic conflict;
    logic grant_wr;
    logic grant_rd;

    assign wr_elig  = push_req && !full_w;
    assign rd_elig  = pop_req  && !empty_w;
    assign conflict = rst_n && wr_elig && rd_elig;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst_n) begin
            // Strobes are held low for the whole reset, independent of the
            // clock, so a request arriving during reset never reaches memory.
            grant_wr = 1'b0;
            grant_rd = 1'b0;
        end else if (wr_elig && rd_elig) begin
            if (prio_q == PRIO_WRITE) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else begin
            grant_wr = wr_elig;
            grant_rd = rd_elig;
        end
    end

    assign wr_fifo  = grant_wr;
    assign rd_fifo  = grant_rd;
    assign push_ack = grant_wr;
    assign pop_ack  = grant_rd;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        prio_d   = prio_q;

        // Pointers are exactly PTR_W bits wide, so the increment wraps from
        // ADDR_DEPTH-1 back to 0 on its own.
        if (grant_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (grant_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end

        // Alternate the winner only on cycles where both sides competed.
        if (conflict) begin
            prio_d = (prio_q == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            prio_q      <= PRIO_WRITE;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            prio_q      <= prio_d;
            // The memory registers rd_data, so the popped word appears one
            // cycle after the read strobe.
            pop_valid_q <= grant_rd;
        end
    end

    // -------------------------------------------------------------------------
    // Memory-side outputs
    // -------------------------------------------------------------------------
    assign wr_addr   = ADDR_DEPTH'(wr_ptr_q);
    assign rd_addr   = ADDR_DEPTH'(rd_ptr_q);
    assign wr_data   = push_data;
    assign pop_valid = pop_valid_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
//
// Directed bench for fifo_ctrl with default parameters (16 x 16). A small
// memory model stands in for the external FIFO RAM, so popped data can be
// compared against the words pushed earlier. Inputs change on the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        push_req;
    logic [15:0] push_data;
    logic        push_ack;
    logic        pop_req;
    logic        pop_ack;
    logic        pop_valid;
    logic        wr_fifo;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_fifo;
    logic [15:0] rd_addr;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;

    logic [15:0] mem [16];
    logic [15:0] rd_data;

    int n_tests;
    int n_fail;

    fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_req     (push_req),
        .push_data    (push_data),
        .push_ack     (push_ack),
        .pop_req      (pop_req),
        .pop_ack      (pop_ack),
        .pop_valid    (pop_valid),
        .wr_fifo      (wr_fifo),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_fifo      (rd_fifo),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: honours one strobe per cycle, registered read data.
    always @(posedge clk) begin
        if (wr_fifo) mem[wr_addr[3:0]] <= wr_data;
        if (rd_fifo) rd_data <= mem[rd_addr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [15:0] d, input logic r);
        @(negedge clk);
        push_req  = p;
        push_data = d;
        pop_req   = r;
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rd_data   = '0;
        rst_n     = 1'b0;
        push_req  = 1'b1;   // a request during reset must not be granted
        push_data = 16'hDEAD;
        pop_req   = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_count",     32'(count),        32'd0);
        check("rst_empty",     32'(empty),        32'd1);
        check("rst_ae",        32'(almost_empty), 32'd1);
        check("rst_full",      32'(full),         32'd0);
        check("rst_af",        32'(almost_full),  32'd0);
        check("rst_wr_fifo",   32'(wr_fifo),      32'd0);
        check("rst_rd_fifo",   32'(rd_fifo),      32'd0);
        check("rst_pop_valid", 32'(pop_valid),    32'd0);
        check("rst_wr_addr",   32'(wr_addr),      32'd0);
        check("rst_wr_data",   32'(wr_data),      32'hDEAD);

        @(negedge clk);
        rst_n    = 1'b1;
        push_req = 1'b0;

        // ---------------- fill 16 words ----------------
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'(i + 1), 1'b0);
            check($sformatf("fill_ack_%0d", i),   32'(push_ack),     32'd1);
            check($sformatf("fill_addr_%0d", i),  32'(wr_addr),      32'(i));
            check($sformatf("fill_count_%0d", i), 32'(count),        32'(i));
            check($sformatf("fill_af_%0d", i),    32'(almost_full),  32'(i >= 14));
            check($sformatf("fill_ae_%0d", i),    32'(almost_empty), 32'(i <= 2));
            check($sformatf("fill_full_%0d", i),  32'(full),         32'd0);
        end
        drive(1'b1, 16'h0011, 1'b0);
        check("full_flag",    32'(full),        32'd1);
        check("full_count",   32'(count),       32'd16);
        check("full_ack17",   32'(push_ack),    32'd0);
        check("full_wr_fifo", 32'(wr_fifo),     32'd0);
        check("full_wr_wrap", 32'(wr_addr),     32'd0);
        check("full_af",      32'(almost_full), 32'd1);

        // ---------------- drain 16 words ----------------
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            check($sformatf("drain_ack_%0d", i),   32'(pop_ack),      32'd1);
            check($sformatf("drain_wrf_%0d", i),   32'(wr_fifo),      32'd0);
            check($sformatf("drain_addr_%0d", i),  32'(rd_addr),      32'(i));
            check($sformatf("drain_count_%0d", i), 32'(count),        32'(16 - i));
            check($sformatf("drain_ae_%0d", i),    32'(almost_empty), 32'((16 - i) <= 2));
            check($sformatf("drain_pv_%0d", i),    32'(pop_valid),    32'(i != 0));
            if (i > 0) check($sformatf("drain_data_%0d", i), 32'(rd_data), 32'(i));
        end
        drive(1'b0, 16'h0000, 1'b1);
        check("drain_last_pv",   32'(pop_valid), 32'd1);
        check("drain_last_data", 32'(rd_data),   32'h0010);
        check("drain_empty",     32'(empty),     32'd1);
        check("drain_count",     32'(count),     32'd0);
        check("pop_empty_ack",   32'(pop_ack),   32'd0);
        drive(1'b0, 16'h0000, 1'b0);
        check("drain_pv_off",    32'(pop_valid), 32'd0);

        // ---------------- conflict arbitration at count=5 ----------------
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h0021 + i), 1'b0);
        drive(1'b1, 16'h00A0, 1'b1);
        check("arb0_count", 32'(count),              32'd5);
        check("arb0_push",  32'(push_ack),           32'd1);
        check("arb0_pop",   32'(pop_ack),            32'd0);
        check("arb0_excl",  32'(wr_fifo && rd_fifo), 32'd0);
        drive(1'b1, 16'h00A1, 1'b1);
        check("arb1_push",  32'(push_ack),           32'd0);
        check("arb1_pop",   32'(pop_ack),            32'd1);
        check("arb1_excl",  32'(wr_fifo && rd_fifo), 32'd0);
        drive(1'b1, 16'h00A1, 1'b1);
        check("arb2_push",  32'(push_ack),           32'd1);
        check("arb2_pop",   32'(pop_ack),            32'd0);
        check("arb2_pv",    32'(pop_valid),          32'd1);
        check("arb2_data",  32'(rd_data),            32'h0021);
        drive(1'b1, 16'h00A2, 1'b1);
        check("arb3_push",  32'(push_ack),           32'd0);
        check("arb3_pop",   32'(pop_ack),            32'd1);
        check("arb3_excl",  32'(wr_fifo && rd_fifo), 32'd0);
        drive(1'b0, 16'h0000, 1'b0);
        check("arb_end_count", 32'(count),     32'd5);
        check("arb_end_data",  32'(rd_data),   32'h0022);

        // ---------------- no fall-through when empty ----------------
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            check($sformatf("flush_ack_%0d", i), 32'(pop_ack), 32'd1);
        end
        drive(1'b1, 16'h0055, 1'b1);
        check("ft_empty",    32'(empty),    32'd1);
        check("ft_push_ack", 32'(push_ack), 32'd1);
        check("ft_pop_ack",  32'(pop_ack),  32'd0);
        drive(1'b0, 16'h0000, 1'b1);
        check("ft_pop_next", 32'(pop_ack),  32'd1);
        check("ft_rd_addr",  32'(rd_addr),  32'd7);
        check("ft_wr_addr",  32'(wr_addr),  32'd8);
        drive(1'b0, 16'h0000, 1'b0);
        check("ft_pv",       32'(pop_valid), 32'd1);
        check("ft_data",     32'(rd_data),   32'h0055);
        check("ft_empty2",   32'(empty),     32'd1);

        // ---------------- asynchronous reset mid-operation ----------------
        for (int i = 0; i < 8; i++) drive(1'b1, 16'(16'h0031 + i), 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_count", 32'(count),   32'd8);
        check("pre_rst_wrf",   32'(wr_fifo), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_count",    32'(count),    32'd0);
        check("arst_empty",    32'(empty),    32'd1);
        check("arst_wr_fifo",  32'(wr_fifo),  32'd0);
        check("arst_push_ack", 32'(push_ack), 32'd0);
        check("arst_wr_addr",  32'(wr_addr),  32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        push_req  = 1'b1;
        push_data = 16'h0077;
        #1;
        check("post_rst_ack",  32'(push_ack), 32'd1);
        check("post_rst_addr", 32'(wr_addr),  32'd0);

        // ---------------- push while full with pop pending ----------------
        for (int i = 0; i < 15; i++) drive(1'b1, 16'(16'h0078 + i), 1'b0);
        drive(1'b1, 16'h0099, 1'b1);
        check("fullpp_full",     32'(full),     32'd1);
        check("fullpp_push_ack", 32'(push_ack), 32'd0);
        check("fullpp_pop_ack",  32'(pop_ack),  32'd1);
        check("fullpp_rd_addr",  32'(rd_addr),  32'd0);
        drive(1'b0, 16'h0000, 1'b0);
        check("fullpp_pv",       32'(pop_valid), 32'd1);
        check("fullpp_data",     32'(rd_data),   32'h0077);
        check("fullpp_count",    32'(count),     32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
